// File: rtl/sweep_seq_pkg.sv
// rtl/sweep_seq_pkg.sv - shared state encoding and constants for the sweep sequencer
// Contents: one-hot state type, timeout data sentinel, default timing constants.
package sweep_seq_pkg;

    typedef enum logic [7:0] {
        ST_IDLE    = 8'b0000_0001,
        ST_SETTLE  = 8'b0000_0010,
        ST_MEAS    = 8'b0000_0100,
        ST_STORE   = 8'b0000_1000,
        ST_STEP_HI = 8'b0001_0000,
        ST_STEP_LO = 8'b0010_0000,
        ST_EXIT    = 8'b0100_0000,
        ST_DONE    = 8'b1000_0000
    } sweep_state_t;

    // Written in place of a measurement when the measurement block never answers.
    localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

    localparam int DEFAULT_N_POINTS     = 16;
    localparam int DEFAULT_SETTLE_CYC   = 50000;   // 1 ms at 50 MHz
    localparam int DEFAULT_MEAS_TIMEOUT = 500000;  // 10 ms at 50 MHz
    localparam int DEFAULT_PULSE_CYC    = 4;

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with expiry flag
// Ports: clk_50m      system clock
//        rst_n        asynchronous active-low reset (count cleared)
//        load         reload the count from load_val this cycle
//        load_val     value loaded; the timer expires load_val cycles later
//        expired      high while the count is zero
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk_50m,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sweep_seq.sv
// rtl/sweep_seq.sv - learn-mode frequency sweep sequencer
// Ports: clk_50m, rst_n            clock, asynchronous active-low reset
//        start, abort              sweep request (IDLE only), level abort
//        freq                      current frequency code from the controller
//        meas_done, meas_data      measurement strobe and result
//        learn_en, next_freq       learn-mode level and step pulse to the controller
//        meas_start                one-cycle measurement request
//        wr_en, wr_addr, wr_data   result RAM write port, data = {freq, meas}
//        busy, done, err           status: not idle, end pulse, sticky error
module sweep_seq
    import sweep_seq_pkg::*;
#(
    parameter int N_POINTS     = DEFAULT_N_POINTS,
    parameter int SETTLE_CYC   = DEFAULT_SETTLE_CYC,
    parameter int MEAS_TIMEOUT = DEFAULT_MEAS_TIMEOUT,
    parameter int PULSE_CYC    = DEFAULT_PULSE_CYC
) (
    input  logic                        clk_50m,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [15:0]                 freq,
    input  logic                        meas_done,
    input  logic [15:0]                 meas_data,
    output logic                        learn_en,
    output logic                        next_freq,
    output logic                        meas_start,
    output logic                        wr_en,
    output logic [$clog2(N_POINTS)-1:0] wr_addr,
    output logic [31:0]                 wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int AW      = $clog2(N_POINTS);
    localparam int CNT_MAX = (SETTLE_CYC > MEAS_TIMEOUT) ? SETTLE_CYC : MEAS_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Timer reload values: a state lasting D cycles loads D-1. MEAS loads the
    // full timeout because its first cycle (the request cycle) never accepts
    // an answer, leaving MEAS_TIMEOUT cycles in which meas_done is honoured.
    // EXIT lasts one extra cycle so done lands PULSE_CYC+1 after learn_en falls.
    localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] LD_MEAS   = CW'(MEAS_TIMEOUT);
    localparam logic [CW-1:0] LD_PULSE  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] LD_EXIT   = CW'(PULSE_CYC);
    localparam logic [AW-1:0] LAST_IDX  = AW'(N_POINTS - 1);

    sweep_state_t  state, state_next;
    logic [AW-1:0] idx, idx_next;
    logic          err_next;
    logic          cap_en;
    logic [15:0]   cap_data;
    logic          timer_load;
    logic [CW-1:0] timer_val;
    logic          timer_expired;

    cycle_timer #(.W(CW)) u_timer (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx;
        err_next   = err;
        cap_en     = 1'b0;
        cap_data   = meas_data;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                    idx_next   = '0;
                    err_next   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_EXIT;
                    err_next   = 1'b1;
                end else if (timer_expired) begin
                    state_next = ST_MEAS;
                end
            end
            ST_MEAS: begin
                // meas_start is still high only on the request cycle, so a
                // strobe coincident with the request is ignored.
                if (abort) begin
                    state_next = ST_EXIT;
                    err_next   = 1'b1;
                end else if (meas_done && !meas_start) begin
                    cap_en     = 1'b1;
                    state_next = ST_STORE;
                end else if (timer_expired) begin
                    cap_en     = 1'b1;
                    cap_data   = TIMEOUT_DATA;
                    err_next   = 1'b1;
                    state_next = ST_STORE;
                end
            end
            ST_STORE: begin
                if (abort) begin
                    state_next = ST_EXIT;
                    err_next   = 1'b1;
                end else if (idx == LAST_IDX) begin
                    state_next = ST_EXIT;
                end else begin
                    state_next = ST_STEP_HI;
                end
            end
            ST_STEP_HI: begin
                if (abort) begin
                    state_next = ST_EXIT;
                    err_next   = 1'b1;
                end else if (timer_expired) begin
                    state_next = ST_STEP_LO;
                end
            end
            ST_STEP_LO: begin
                if (abort) begin
                    state_next = ST_EXIT;
                    err_next   = 1'b1;
                end else if (timer_expired) begin
                    state_next = ST_SETTLE;
                    idx_next   = idx + AW'(1);
                end
            end
            ST_EXIT: begin
                if (timer_expired) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Every state change restarts the timer with the new state's duration.
        timer_load = (state_next != state);
        case (state_next)
            ST_SETTLE:             timer_val = LD_SETTLE;
            ST_MEAS:               timer_val = LD_MEAS;
            ST_STEP_HI, ST_STEP_LO: timer_val = LD_PULSE;
            ST_EXIT:               timer_val = LD_EXIT;
            default:               timer_val = '0;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            err        <= 1'b0;
            learn_en   <= 1'b0;
            next_freq  <= 1'b0;
            meas_start <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            err        <= err_next;
            learn_en   <= state_next inside {ST_SETTLE, ST_MEAS, ST_STORE, ST_STEP_HI, ST_STEP_LO};
            next_freq  <= (state_next == ST_STEP_HI);
            meas_start <= (state_next == ST_MEAS) && (state != ST_MEAS);
            wr_en      <= (state_next == ST_STORE);
            busy       <= (state_next != ST_IDLE);
            done       <= (state_next == ST_DONE);
            if (state_next == ST_STORE) wr_addr <= idx;
            if (cap_en) wr_data <= {freq, cap_data};
        end
    end

endmodule

// File: doc/sweep_seq.md
# sweep_seq

Learn-mode sweep sequencer on clk_50m. Puts the DDS frequency controller into learn mode, waits a settle time at each point, handshakes one measurement per point with the measurement block and writes the result into a result RAM. Between points it steps the tone with one `next_freq` pulse. At the end it restores normal mode. It sits between the top-level key/command logic and the frequency-control/DDS block, and replaces manual toggling of `learn_en`/`next_freq`.

## Interface
Parameters:
- N_POINTS, 16: number of sweep points (controller steps +2 per point from 10, i.e. freq codes 10..40).
- SETTLE_CYC, 50000: clk_50m cycles waited after each frequency change before measuring (1 ms).
- MEAS_TIMEOUT, 500000: max cycles to wait for `meas_done` (10 ms).
- PULSE_CYC, 4: high time and low time of each `next_freq` pulse, and hold time in EXIT.

Ports:
- clk_50m  in  1  system clock. Reset is rst_n, asynchronous, active-low; clock is clk_50m.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  sweep request, sampled only in IDLE.
- abort  in  1  terminate sweep, level, sampled every cycle.
- freq  in  16  current frequency code from the frequency controller (freq*100 Hz).
- meas_done  in  1  measurement-complete strobe.
- meas_data  in  16  measurement result, valid with `meas_done`.
- learn_en  out  1  learn-mode level to the frequency controller.
- next_freq  out  1  step pulse to the frequency controller.
- meas_start  out  1  one-cycle measurement request.
- wr_en  out  1  result RAM write strobe.
- wr_addr  out  $clog2(N_POINTS)  result index.
- wr_data  out  32  {freq[15:0], meas_data[15:0]}.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle end-of-sweep pulse.
- err  out  1  sticky: timeout or abort in the last sweep; cleared on the next accepted start.

## Operation
- All outputs are registered. Reset value of every output is 0. After reset the state is IDLE, idx=0 and counters=0.
- States: IDLE, SETTLE, MEAS, STORE, STEP_HI, STEP_LO, EXIT, DONE.
- IDLE: `start`=1 → SETTLE, `learn_en`←1, idx←0, err←0.
- SETTLE: counts SETTLE_CYC cycles → MEAS. This also covers the controller's 2-flop edge detection and its reload of freq code 10.
- MEAS: `meas_start` is high for exactly the first cycle.
  - `meas_done` on any later cycle → capture `meas_data` and `freq`, go to STORE.
  - No `meas_done` within MEAS_TIMEOUT cycles → capture 16'hFFFF as data, set err, go to STORE.
  - `meas_done` on the same cycle as `meas_start` is ignored.
- STORE: one cycle with `wr_en`=1, `wr_addr`=idx and `wr_data` = the captured {freq, data}.
  - idx = N_POINTS-1 → EXIT.
  - Otherwise → STEP_HI.
- STEP_HI: `next_freq`=1 for PULSE_CYC cycles → STEP_LO.
- STEP_LO: `next_freq`=0 for PULSE_CYC cycles, idx←idx+1 on exit → SETTLE.
- EXIT: `learn_en`←0 and held for PULSE_CYC cycles, letting the controller restore the saved frequency → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- abort=1 in SETTLE/MEAS/STEP_HI/STEP_LO → EXIT next cycle, set err, force `next_freq`=0.
  - abort in STORE: the write still completes, then → EXIT.
  - abort in EXIT/DONE/IDLE has no effect.
- `start` while busy is ignored. idx never wraps; the last point always goes to EXIT.
- No `wr_en` after an abort is taken.

## Timing
- start accepted at cycle 0 → `learn_en`=1 and `busy`=1 at cycle 1.
- First `meas_start` at cycle 1+SETTLE_CYC.
- `meas_done` at cycle t → `wr_en` at t+1.
- Point-to-point period = 2*PULSE_CYC + SETTLE_CYC + 2 + measurement time.
- `done` occurs PULSE_CYC+1 cycles after `learn_en` falls; `busy` drops on the cycle after `done`.
- Reset mid-sweep: all outputs go to 0 asynchronously, so `learn_en` falls and the controller returns to normal mode.
- Counter width is $clog2(max(SETTLE_CYC, MEAS_TIMEOUT)+1). The counter is cleared on every state entry.

## Structure
- A shared package holds the state encoding (one-hot, 8 bits), the 16'hFFFF timeout sentinel and the default SETTLE/TIMEOUT constants reused by the top level.
- One sub-module, `cycle_timer`: a loadable down-counter with a `expired` flag, shared by SETTLE, MEAS timeout, STEP and EXIT. The FSM and datapath stay in sweep_seq.

## Test plan
Use N_POINTS=4, SETTLE_CYC=20, MEAS_TIMEOUT=50, PULSE_CYC=4, with a model controller (freq 10, +2 per `next_freq`).
- Normal sweep, `meas_done` 5 cycles after each `meas_start` with data 0x0100+idx → 4 writes: addr 0..3, wr_data {10,0x0100} … {16,0x0103}; 3 `next_freq` pulses each 4 cycles high; `done` once; err=0.
- Point 2 never answers → write at addr 2 = {14,0xFFFF} exactly 51 cycles after its `meas_start`; sweep continues to addr 3; err=1 after `done`.
- Abort in SETTLE of point 1 → `learn_en`=0 next cycle, no further `wr_en`, `done` 5 cycles later, err=1.
- `start` held high throughout → exactly one sweep per IDLE entry; `start` during busy has no effect.
- `meas_done` coincident with `meas_start` plus a second `meas_done` 3 cycles later → only the second is captured.
- rst_n asserted mid-STEP_HI → all outputs 0 immediately; after release, state IDLE and a new start gives a full 4-point sweep.
